muldiv_unit: RTL and testbench

- Iterative multiply/divide unit implementing RV32M.
- Sits in the execute stage beside the alu and consumes the same register-file operands on A and B.
- Its result joins the alu_out into the writeback mux; control holds the PC while busy is high.
- Multi-cycle, fixed latency, start/done handshake.

---
 rtl/muldiv_unit_if.sv | 16 +
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and operand/result bundle between the execute-stage control and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            Zero;

  modport master (output start, op, A, B, input busy, done, result, Zero);
  modport slave  (input start, op, A, B, output busy, done, result, Zero);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: XLEN shift-add or restoring-divide steps on operand magnitudes,
// followed by one cycle of sign correction and special-case selection.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic            clk,
  input logic            rst,
  muldiv_unit_if.slave   bus
);

  localparam int              CW        = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic              bzero_q, bzero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin;

  // Operand decode happens on the live bus so magnitudes are ready at the accepting edge.
  always_comb begin
    a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
               (bus.op == OP_DIV)  || (bus.op == OP_REM);
    b_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    a_neg    = a_signed && bus.A[XLEN-1];
    b_neg    = b_signed && bus.B[XLEN-1];
    a_mag    = a_neg ? (~bus.A + 1'b1) : bus.A;
    b_mag    = b_neg ? (~bus.B + 1'b1) : bus.B;
  end

  // acc holds {high, low} product while multiplying and {remainder, quotient} while dividing.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_diff[XLEN];
    div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ok};
  end

  // Divide-by-zero bypasses the corrected values; signed overflow falls out of the magnitude math.
  always_comb begin
    prod_s = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_s  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_s  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        fin = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fin = bzero_q ? '1 : quo_s;
      default:                       fin = bzero_q ? a_q : rem_s;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d      = bus.op;
          a_d       = bus.A;
          opnd_d    = bus.op[2] ? b_mag : a_mag;
          acc_d     = {{XLEN{1'b0}}, (bus.op[2] ? a_mag : b_mag)};
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          bzero_d   = (bus.B == '0);
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        result_d = fin;
        zero_d   = (fin == '0);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.Zero   = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: result/Zero/latency table plus handshake and reset sequences.
module tb_muldiv_unit;

  localparam int XLEN     = 32;
  localparam int LAT_EXP  = XLEN + 2;  // negedges from start drive to first done sample
  localparam int BUSY_EXP = XLEN + 1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Drives start in the current cycle, scrambles inputs after acceptance, optionally pulses a
  // second start at cycle inject_at, and returns at the negedge where done is seen.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inject_at, output logic [31:0] res, output logic zf,
                       output int lat, output int bcnt);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    lat       = 0;
    bcnt      = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.A     = ~a;
        bus.B     = b + 32'd1;
      end
      if (inject_at != 0 && c == inject_at) begin
        bus.start = 1'b1;
        bus.op    = 3'b101;
        bus.A     = 32'd1;
        bus.B     = 32'd1;
      end
      if (inject_at != 0 && c == inject_at + 1) bus.start = 1'b0;
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    res = bus.result;
    zf  = bus.Zero;
  endtask

  vec_t        vecs [16];
  logic [31:0] res;
  logic        zf;
  int          lat;
  int          bcnt;
  int          dcnt;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    vecs[3]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
    vecs[4]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
    vecs[5]  = '{3'b101, 32'd100,      32'd7,        32'd14};
    vecs[6]  = '{3'b111, 32'd100,      32'd7,        32'd2};
    vecs[7]  = '{3'b101, 32'd10,       32'd0,        32'hFFFFFFFF};
    vecs[8]  = '{3'b111, 32'd10,       32'd0,        32'h0000000A};
    vecs[9]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[10] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[11] = '{3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF};
    vecs[12] = '{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB};
    vecs[13] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[14] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[15] = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    check("reset busy",   {31'd0, bus.busy}, 32'd0);
    check("reset done",   {31'd0, bus.done}, 32'd0);
    check("reset result", bus.result,        32'd0);
    check("reset Zero",   {31'd0, bus.Zero}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    do_op(3'b000, 32'd5, 32'd3, 0, res, zf, lat, bcnt);
    check("mul5x3 result",  res,            32'h0000000F);
    check("mul5x3 Zero",    {31'd0, zf},    32'd0);
    check("mul5x3 latency", lat,            LAT_EXP);
    check("mul5x3 busy",    bcnt,           BUSY_EXP);
    @(negedge clk);
    check("done one cycle", {31'd0, bus.done}, 32'd0);

    // Every vector after the first starts in the done cycle of its predecessor.
    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, zf, lat, bcnt);
      check($sformatf("vec%0d op%0d result", i, vecs[i].op), res, vecs[i].exp);
      check($sformatf("vec%0d Zero", i), {31'd0, zf}, {31'd0, (vecs[i].exp == 32'd0)});
      check($sformatf("vec%0d latency", i), lat, LAT_EXP);
    end

    do_op(3'b000, 32'd9, 32'd9, 10, res, zf, lat, bcnt);
    check("ignored start result",  res, 32'd81);
    check("ignored start latency", lat, LAT_EXP);
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check("ignored start extra dones", dcnt, 32'd0);

    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.A     = 32'd1000;
    bus.B     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    check("busy before abort", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort busy",   {31'd0, bus.busy}, 32'd0);
    check("abort done",   {31'd0, bus.done}, 32'd0);
    check("abort result", bus.result,        32'd0);
    check("abort Zero",   {31'd0, bus.Zero}, 32'd1);
    #1 rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check("abort no done", dcnt, 32'd0);

    do_op(3'b000, 32'd6, 32'd7, 0, res, zf, lat, bcnt);
    check("mul6x7 result",  res, 32'h0000002A);
    check("mul6x7 latency", lat, LAT_EXP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
